// File: rtl/wall_if.sv
// Control/status bundle for the wall generator.
// master: game controller side; slave: wall_generator side.
interface wall_if;
   logic       tick;
   logic       start;
   logic       freeze;
   logic [7:0] wall_xleft;
   logic [7:0] wall_xright;
   logic [6:0] wall_topy;
   logic [6:0] wall_bottomy;
   logic       wall_valid;
   logic       wall_passed;

   modport master (
      output tick, start, freeze,
      input  wall_xleft, wall_xright, wall_topy, wall_bottomy, wall_valid, wall_passed
   );

   modport slave (
      input  tick, start, freeze,
      output wall_xleft, wall_xright, wall_topy, wall_bottomy, wall_valid, wall_passed
   );
endinterface

// File: rtl/wall_generator.sv
// Scrolling wall with a random vertical gap; respawns at the right edge after leaving on the left.
// Optional macro WALL_SPEEDUP_EN: scroll step grows by 1 every 4 walls passed, saturating at 4.
module wall_generator #(
   parameter int SCREEN_W = 160,
   parameter int WALL_W   = 10,
   parameter int GAP_H    = 40,
   parameter int GAP_MIN  = 10,
   parameter int STEP     = 1
) (
   input  logic  clock,
   input  logic  reset,
   wall_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_RESPAWN = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   localparam logic [7:0] SPAWN_X  = 8'(SCREEN_W - WALL_W);
   localparam logic [7:0] XR_OFS   = 8'(WALL_W - 1);
   localparam logic [6:0] TOP_RST  = 7'(GAP_MIN) + 7'h25;
   localparam logic [6:0] GAP_OFS  = 7'(GAP_H);

   state_t     r_state;
   logic [7:0] r_lfsr;
   logic [7:0] r_xleft;
   logic [7:0] r_xright;
   logic [6:0] r_topy;
   logic [6:0] r_bottomy;
   logic       r_valid;
   logic       r_passed;

   logic       w_lfsr_fb;
   logic [7:0] w_step;
   logic [7:0] w_scroll_x;
   logic [6:0] w_spawn_topy;
   logic       w_wall_out;
   logic       w_start_ok;

   assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_scroll_x   = (r_xleft < w_step) ? 8'd0 : r_xleft - w_step;
   assign w_spawn_topy = 7'(GAP_MIN) + {1'b0, r_lfsr[5:0]};
   assign w_wall_out   = (r_state == S_RUN) && !bus.freeze && bus.tick && (r_xleft == 8'd0);
   assign w_start_ok   = bus.start && ((r_state == S_IDLE) ||
                                       ((r_state == S_HALT) && !bus.freeze));

`ifdef WALL_SPEEDUP_EN
   logic [2:0] r_step;
   logic [1:0] r_pass_cnt;

   // Every fourth wall leaving bumps the step, capped at 4 px per tick.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_step     <= 3'(STEP);
         r_pass_cnt <= 2'd0;
      end else if (w_start_ok) begin
         r_step     <= 3'(STEP);
         r_pass_cnt <= 2'd0;
      end else if (w_wall_out) begin
         r_pass_cnt <= r_pass_cnt + 2'd1;
         if ((r_pass_cnt == 2'd3) && (r_step < 3'd4))
            r_step <= r_step + 3'd1;
      end
   end

   assign w_step = {5'd0, r_step};
`else
   assign w_step = 8'(STEP);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_lfsr    <= 8'hA5;
         r_xleft   <= SPAWN_X;
         r_xright  <= SPAWN_X + XR_OFS;
         r_topy    <= TOP_RST;
         r_bottomy <= TOP_RST + GAP_OFS;
         r_valid   <= 1'b0;
         r_passed  <= 1'b0;
      end else begin
         r_lfsr   <= {r_lfsr[6:0], w_lfsr_fb};
         r_passed <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= S_RUN;
                  r_valid <= 1'b1;
               end
            end
            S_RUN: begin
               // Freeze beats tick so a collision frame never scrolls.
               if (bus.freeze) begin
                  r_state <= S_HALT;
               end else if (bus.tick) begin
                  if (r_xleft == 8'd0) begin
                     r_state   <= S_RESPAWN;
                     r_xleft   <= SPAWN_X;
                     r_xright  <= SPAWN_X + XR_OFS;
                     r_topy    <= w_spawn_topy;
                     r_bottomy <= w_spawn_topy + GAP_OFS;
                     r_passed  <= 1'b1;
                  end else begin
                     r_xleft  <= w_scroll_x;
                     r_xright <= w_scroll_x + XR_OFS;
                  end
               end
            end
            S_RESPAWN: begin
               r_state <= bus.freeze ? S_HALT : S_RUN;
            end
            S_HALT: begin
               if (bus.start && !bus.freeze) begin
                  r_state   <= S_RUN;
                  r_xleft   <= SPAWN_X;
                  r_xright  <= SPAWN_X + XR_OFS;
                  r_topy    <= w_spawn_topy;
                  r_bottomy <= w_spawn_topy + GAP_OFS;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.wall_xleft   = r_xleft;
   assign bus.wall_xright  = r_xright;
   assign bus.wall_topy    = r_topy;
   assign bus.wall_bottomy = r_bottomy;
   assign bus.wall_valid   = r_valid;
   assign bus.wall_passed  = r_passed;

endmodule

// File: tb/tb_wall_generator.sv
// Self-checking bench for wall_generator: directed scenarios then random play against a reference model.
module tb_wall_generator;

   localparam int SCREEN_W = 160;
   localparam int WALL_W   = 10;
   localparam int GAP_H    = 40;
   localparam int GAP_MIN  = 10;
   localparam int STEP     = 1;
   localparam int SPAWN    = SCREEN_W - WALL_W;

   logic clock;
   logic reset;
   wall_if bus ();

   wall_generator #(
      .SCREEN_W (SCREEN_W),
      .WALL_W   (WALL_W),
      .GAP_H    (GAP_H),
      .GAP_MIN  (GAP_MIN),
      .STEP     (STEP)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp;
   int n_bad;

   // Reference model: mode 0 idle, 1 running, 2 respawn cycle, 3 halted.
   int m_mode;
   int m_x;
   int m_top;
   int m_valid;
   int m_passed;
   int m_lfsr;
   int m_walls;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lfsr_next(input int l);
      int fb;
      fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
      return ((l << 1) | fb) & 255;
   endfunction

   function automatic int cur_step();
`ifdef WALL_SPEEDUP_EN
      int s;
      s = STEP + m_walls / 4;
      return (s > 4) ? 4 : s;
`else
      return STEP;
`endif
   endfunction

   task automatic model_edge(input bit t, input bit s, input bit f, input bit r);
      int l_old;
      int st;
      if (r) begin
         m_mode = 0; m_x = SPAWN; m_top = GAP_MIN + 37;
         m_valid = 0; m_passed = 0; m_lfsr = 8'hA5; m_walls = 0;
         return;
      end
      l_old    = m_lfsr;
      m_lfsr   = lfsr_next(m_lfsr);
      m_passed = 0;
      st       = cur_step();
      case (m_mode)
         0: if (s) begin m_mode = 1; m_valid = 1; m_walls = 0; end
         1: begin
            if (f) m_mode = 3;
            else if (t) begin
               if (m_x == 0) begin
                  m_mode = 2; m_x = SPAWN; m_top = GAP_MIN + (l_old % 64);
                  m_passed = 1; m_walls++;
               end else begin
                  m_x = (m_x < st) ? 0 : m_x - st;
               end
            end
         end
         2: m_mode = f ? 3 : 1;
         default: if (s && !f) begin
            m_mode = 1; m_x = SPAWN; m_top = GAP_MIN + (l_old % 64); m_walls = 0;
         end
      endcase
   endtask

   task automatic compare_all();
      check("xleft",   int'(bus.wall_xleft),   m_x);
      check("xright",  int'(bus.wall_xright),  m_x + WALL_W - 1);
      check("topy",    int'(bus.wall_topy),    m_top);
      check("bottomy", int'(bus.wall_bottomy), m_top + GAP_H);
      check("valid",   int'(bus.wall_valid),   m_valid);
      check("passed",  int'(bus.wall_passed),  m_passed);
      check("topy_range", int'(bus.wall_topy >= 7'd10 && bus.wall_topy <= 7'd73), 1);
   endtask

   task automatic cyc(input bit t, input bit s, input bit f, input bit r);
      bus.tick = t; bus.start = s; bus.freeze = f; reset = r;
      @(posedge clock);
      model_edge(t, s, f, r);
      #1;
      compare_all();
   endtask

   initial begin
      bit fz;
      n_cmp = 0; n_bad = 0;
      bus.tick = 1'b0; bus.start = 1'b0; bus.freeze = 1'b0; reset = 1'b1;

      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      check("rst_xleft",  int'(bus.wall_xleft), 150);
      check("rst_xright", int'(bus.wall_xright), 159);
      check("rst_topy",   int'(bus.wall_topy), 47);
      check("rst_bottom", int'(bus.wall_bottomy), 87);
      check("rst_valid",  int'(bus.wall_valid), 0);
      cyc(1, 0, 0, 0);
      check("idle_tick",  int'(bus.wall_xleft), 150);
      $display("phase reset done");

      cyc(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
      check("run3_xleft",  int'(bus.wall_xleft), 147);
      check("run3_xright", int'(bus.wall_xright), 156);
      check("run3_valid",  int'(bus.wall_valid), 1);
      $display("phase start+3 ticks done");

      for (int i = 0; i < 147; i++) cyc(1, 0, 0, 0);
      check("edge_xleft", int'(bus.wall_xleft), 0);
      cyc(1, 0, 0, 0);
      check("resp_passed", int'(bus.wall_passed), 1);
      check("resp_xleft",  int'(bus.wall_xleft), 150);
      cyc(1, 0, 0, 0);
      check("resp_pulse1", int'(bus.wall_passed), 0);
      $display("phase respawn done");

      while (m_x > 80) cyc(1, 0, 0, 0);
      check("pre_frz_x", int'(bus.wall_xleft), 80);
      cyc(1, 0, 1, 0);
      check("frz_tick_x", int'(bus.wall_xleft), 80);
      for (int i = 0; i < 5; i++) cyc(1, 0, i[0], 0);
      check("halt_x", int'(bus.wall_xleft), 80);
      check("halt_valid", int'(bus.wall_valid), 1);
      cyc(0, 1, 1, 0);
      check("halt_start_frz", int'(bus.wall_xleft), 80);
      cyc(0, 1, 0, 0);
      check("halt_restart", int'(bus.wall_xleft), 150);
      cyc(1, 0, 0, 0);
      check("restart_runs", int'(bus.wall_xleft), 149);
      $display("phase freeze/halt done");

      for (int i = 0; i < 149; i++) cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      check("resp2_passed", int'(bus.wall_passed), 1);
      cyc(1, 0, 0, 1);
      check("rst_resp_passed", int'(bus.wall_passed), 0);
      check("rst_resp_x", int'(bus.wall_xleft), 150);
      check("rst_resp_valid", int'(bus.wall_valid), 0);
      $display("phase reset-in-respawn done");

      cyc(0, 1, 0, 0);
      fz = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         if (!fz && $urandom_range(0, 299) == 0) fz = 1'b1;
         else if (fz && $urandom_range(0, 4) == 0) fz = 1'b0;
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, fz,
             $urandom_range(0, 1999) == 0);
      end
      $display("phase random done, walls since start %0d", m_walls);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
